// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter, MSB first, valid/ready word input
//
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and emits it one
// bit per clock, MSB first, with a qualifying strobe. All outputs are registered.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   din_valid  parallel word offered on din
//   din        parallel word, sampled only on an accept edge
//   din_ready  block can accept a word (IDLE only, low while reset is high)
//   bit_out    serial data, MSB first, 0 whenever bit_valid is 0
//   bit_valid  bit_out carries a frame bit this cycle
//   busy       frame in progress
//   done       one-cycle pulse with the final bit of a frame
//
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.

module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  // The MSB goes straight to bit_out on accept, so only the remaining bits are held.
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      din_ready <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          din_ready <= 1'b1;
          // din_ready is still 0 on the first edge after reset, so no accept there.
          if (din_valid && din_ready) begin
            sr        <= din[WIDTH-2:0];
            cnt       <= CW'(WIDTH - 1);
            bit_out   <= din[WIDTH-1];
            bit_valid <= 1'b1;
            busy      <= 1'b1;
            din_ready <= 1'b0;
            state     <= SHIFT;
`ifdef PISO_PARITY_EN
            par       <= ^din;
`endif
          end
        end

        SHIFT: begin
          if (cnt != '0) begin
            sr      <= sr << 1;
            cnt     <= cnt - CW'(1);
            bit_out <= sr[WIDTH-2];
`ifdef PISO_PARITY_EN
            done    <= 1'b0;
`else
            // Raised together with the last data bit (counter about to hit 0).
            done    <= (cnt == CW'(1));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state     <= PARITY;
            bit_out   <= par;
            bit_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b1;
`else
            state     <= IDLE;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            din_ready <= 1'b1;
`endif
          end
        end

        PARITY: begin
          state     <= IDLE;
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          din_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer against a bit-queue model

module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = W + PAR;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_ready;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           exp_q[$];
  bit           m_ready = 1'b0;
  int           acc_edges[$];
  logic [W-1:0] rx = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: the model decides the accept from pre-edge inputs, then pops the
  // next expected serial bit; outputs are compared 1 time unit after the edge.
  task automatic step();
    bit           pv, pbv, pbo, eb, ev, ed;
    logic [W-1:0] pd;
    pv  = din_valid;
    pd  = din;
    pbv = bit_valid;
    pbo = bit_out;
    @(posedge clk);
    cyc++;
    if (reset) exp_q.delete();
    else if (pv && m_ready) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(pd[i]);
      if (PAR == 1) exp_q.push_back(($countones(pd) % 2) == 1);
      acc_edges.push_back(cyc);
    end
    if (pbv) rx = {rx[W-2:0], pbo};
    if (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      ev = 1'b1;
      ed = (exp_q.size() == 0);
    end else begin
      eb = 1'b0;
      ev = 1'b0;
      ed = 1'b0;
    end
    m_ready = !ev && !reset;
    #1;
    check("bit_valid", bit_valid, ev);
    check("bit_out", bit_out, eb);
    check("done", done, ed);
    check("busy", busy, ev);
    check("din_ready", din_ready, m_ready);
  endtask

  // Reset pulse between clock edges; outputs must clear without any edge.
  task automatic reset_async();
    #2 reset = 1'b1;
    #1;
    check("rst_bit_out", bit_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_din_ready", din_ready, 0);
    exp_q.delete();
    m_ready = 1'b0;
    #2 reset = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!m_ready && n < 50) begin
      step();
      n++;
    end
    if (!m_ready) check("ready_timeout", 0, 1);
  endtask

  // Accept one word and collect its FLEN serial bits (first bit ends up in the MSB).
  task automatic run_frame(input logic [W-1:0] word, output logic [W:0] bits,
                           output int done_cnt, output int done_pos);
    wait_ready();
    din       = word;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    bits     = '0;
    done_cnt = 0;
    done_pos = -1;
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0) step();
      bits = {bits[W-1:0], bit_out};
      if (done) begin
        done_cnt++;
        done_pos = i;
      end
    end
  endtask

  initial begin
    logic [W:0] bits;
    int         dcnt, dpos, dsum;

    #1;
    check("init_bit_out", bit_out, 0);
    check("init_bit_valid", bit_valid, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_din_ready", din_ready, 0);
    repeat (2) step();
    #2 reset = 1'b0;
    step();
    check("post_reset_ready", din_ready, 1);

    run_frame(4'b1011, bits, dcnt, dpos);
    check("sf_bits", bits, (PAR == 1) ? 5'b10111 : 5'b01011);
    check("sf_done_cnt", dcnt, 1);
    check("sf_done_pos", dpos, FLEN - 1);
    step();
`ifndef PISO_PARITY_EN
    check("sf_rx_word", rx, 4'b1011);
`endif

    run_frame(4'b1001, bits, dcnt, dpos);
    check("p2_bits", bits, (PAR == 1) ? 5'b10010 : 5'b01001);
    check("p2_done_pos", dpos, FLEN - 1);

    // back-to-back with din_valid held high
    wait_ready();
    acc_edges.delete();
    din       = 4'h5;
    din_valid = 1'b1;
    step();
    din = 4'hA;
    for (int n = 0; n < 20 && acc_edges.size() < 2; n++) step();
    din_valid = 1'b0;
    check("b2b_accepts", acc_edges.size(), 2);
    if (acc_edges.size() == 2) check("b2b_gap", acc_edges[1] - acc_edges[0], FLEN + 1);
    repeat (FLEN + 2) step();
    check("b2b_no_extra", acc_edges.size(), 2);

    // input offered and changed while busy
    wait_ready();
    acc_edges.delete();
    din       = 4'h6;
    din_valid = 1'b1;
    step();
    din = 4'hF;
    step();
    din = 4'h0;
    step();
    din_valid = 1'b0;
    repeat (FLEN + 2) step();
    check("ign_accepts", acc_edges.size(), 1);

    // reset after the second bit of 4'hC
    wait_ready();
    din       = 4'hC;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    reset_async();
    dsum = 0;
    for (int n = 0; n < FLEN + 2; n++) begin
      step();
      dsum += int'(done);
    end
    check("mid_rst_no_done", dsum, 0);
    run_frame(4'h3, bits, dcnt, dpos);
    check("after_rst_bits", bits, (PAR == 1) ? 5'b00110 : 5'b00011);

    // random traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      din_valid = ($urandom_range(0, 3) != 0);
      din       = W'($urandom);
      step();
      if ($urandom_range(0, 79) == 0) reset_async();
    end
    din_valid = 1'b0;
    repeat (FLEN + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
